fixed_vec_normalize: RTL and testbench



---
 rtl/fixed_vec_normalize.sv | 214 +++++++++++++++++++++
 tb/tb_fixed_vec_normalize.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fixed_vec_normalize.sv
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_vec_normalize                                                      |
// | Divides a 3-component fixed-point vector by its length, one component    |
// | after another, on a STEP-bits-per-clock restoring divider.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fixed_vec_normalize #(
  parameter int WIDTH = `FIXED_WIDTH,
  parameter int FRAC  = 16,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             strobe,
  input  logic [WIDTH-1:0] vec_x,
  input  logic [WIDTH-1:0] vec_y,
  input  logic [WIDTH-1:0] vec_z,
  input  logic [WIDTH-1:0] len,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] norm_x,
  output logic [WIDTH-1:0] norm_y,
  output logic [WIDTH-1:0] norm_z,
  output logic             div_zero
);

  localparam int NUM_W = WIDTH + FRAC;
  localparam int N_CYC = NUM_W / STEP;
  localparam int CNT_W = (N_CYC > 1) ? $clog2(N_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);
  localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       comp_q, comp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [NUM_W-1:0] qn_q, qn_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] vy_q, vy_d;
  logic [WIDTH-1:0] vz_q, vz_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic [WIDTH-1:0] nx_q, nx_d;
  logic [WIDTH-1:0] ny_q, ny_d;
  logic [WIDTH-1:0] nz_q, nz_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             dz_q, dz_d;

  // qn holds the unconsumed numerator bits on top and shifts quotient bits in below
  logic [WIDTH:0]   step_rem;
  logic [NUM_W-1:0] step_qn;

  always_comb begin
    step_rem = rem_q;
    step_qn  = qn_q;
    for (int i = 0; i < STEP; i++) begin
      step_rem = {step_rem[WIDTH-1:0], step_qn[NUM_W-1]};
      step_qn  = {step_qn[NUM_W-2:0], 1'b0};
      if (step_rem >= {1'b0, len_q}) begin
        step_rem   = step_rem - {1'b0, len_q};
        step_qn[0] = 1'b1;
      end
    end
  end

  logic             quo_sat;
  logic [WIDTH-1:0] res_mag;
  logic [WIDTH-1:0] res_val;

  assign quo_sat = |step_qn[NUM_W-1:WIDTH-1];
  assign res_mag = quo_sat ? MAG_MAX : step_qn[WIDTH-1:0];
  assign res_val = neg_q ? (WIDTH'(0) - res_mag) : res_mag;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude
  logic [WIDTH-1:0] ld_src;
  logic [WIDTH-1:0] ld_mag;
  logic [NUM_W-1:0] ld_num;
  logic             len_nonpos;

  assign ld_src     = (state_q == S_IDLE) ? vec_x : ((comp_q == 2'd0) ? vy_q : vz_q);
  assign ld_mag     = ld_src[WIDTH-1] ? (WIDTH'(0) - ld_src) : ld_src;
  assign ld_num     = {ld_mag, {FRAC{1'b0}}};
  assign len_nonpos = len[WIDTH-1] | (len == '0);

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qn_d    = qn_q;
    neg_d   = neg_q;
    vy_d    = vy_q;
    vz_d    = vz_q;
    len_d   = len_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nz_d    = nz_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE: begin
        if (strobe) begin
          vy_d   = vec_y;
          vz_d   = vec_z;
          len_d  = len;
          comp_d = 2'd0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (len_nonpos) begin
            dz_d    = 1'b1;
            nx_d    = '0;
            ny_d    = '0;
            nz_d    = '0;
            state_d = S_DONE;
          end else begin
            dz_d    = 1'b0;
            neg_d   = ld_src[WIDTH-1];
            rem_d   = '0;
            qn_d    = ld_num;
            state_d = S_DIV;
          end
        end
      end

      S_DIV: begin
        rem_d = step_rem;
        qn_d  = step_qn;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (comp_q)
            2'd0:    nx_d = res_val;
            2'd1:    ny_d = res_val;
            default: nz_d = res_val;
          endcase
          if (comp_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            comp_d = comp_q + 2'd1;
            neg_d  = ld_src[WIDTH-1];
            rem_d  = '0;
            qn_d   = ld_num;
          end
        end
      end

      S_DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      comp_q  <= 2'd0;
      cnt_q   <= '0;
      rem_q   <= '0;
      qn_q    <= '0;
      neg_q   <= 1'b0;
      vy_q    <= '0;
      vz_q    <= '0;
      len_q   <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      nz_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qn_q    <= qn_d;
      neg_q   <= neg_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      len_q   <= len_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      nz_q    <= nz_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign norm_x   = nx_q;
  assign norm_y   = ny_q;
  assign norm_z   = nz_q;
  assign div_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_vec_normalize.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fixed_vec_normalize                                                   |
// | Directed vectors with hand-computed results for fixed_vec_normalize.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fixed_vec_normalize;

  logic        clk;
  logic        resetn;
  logic        strobe;
  logic [31:0] vec_x, vec_y, vec_z, len;
  logic        busy, valid, div_zero;
  logic [31:0] norm_x, norm_y, norm_z;

  int n_vec = 0;
  int n_err = 0;

  fixed_vec_normalize dut (
    .clk      (clk),
    .resetn   (resetn),
    .strobe   (strobe),
    .vec_x    (vec_x),
    .vec_y    (vec_y),
    .vec_z    (vec_z),
    .len      (len),
    .busy     (busy),
    .valid    (valid),
    .norm_x   (norm_x),
    .norm_y   (norm_y),
    .norm_z   (norm_z),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [31:0] l);
    vec_x  = x;
    vec_y  = y;
    vec_z  = z;
    len    = l;
    strobe = 1'b1;
  endtask

  // Called 1ns after an edge while idle; returns 1ns after the accepting edge.
  task automatic req_start(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [31:0] l);
    drive(x, y, z, l);
    @(posedge clk);
    #1;
    strobe = 1'b0;
    chk({tag, "_busy_acc"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic check_result(input string tag, input int exp_lat,
                              input logic [31:0] ex, input logic [31:0] ey,
                              input logic [31:0] ez, input logic edz);
    int lat;
    lat = -1;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (valid) lat = k;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_nx"}, norm_x, ex);
    chk({tag, "_ny"}, norm_y, ey);
    chk({tag, "_nz"}, norm_z, ez);
    chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    chk({tag, "_busy_v"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int nv;
    resetn = 1'b0;
    strobe = 1'b0;
    vec_x  = '0;
    vec_y  = '0;
    vec_z  = '0;
    len    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_dz", {31'd0, div_zero}, 32'd0);
    chk("rst_nx", norm_x, 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    req_start("unit", 32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0005_0000);
    check_result("unit", 37, 32'h0000_9999, 32'h0000_CCCC, 32'h0, 1'b0);

    req_start("len0", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0);
    check_result("len0", 1, 32'h0, 32'h0, 32'h0, 1'b1);

    req_start("lenneg", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'hFFFF_0000);
    check_result("lenneg", 1, 32'h0, 32'h0, 32'h0, 1'b1);

    req_start("sign", 32'hFFFD_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0005_0000);
    check_result("sign", 37, 32'hFFFF_6667, 32'h0000_CCCC, 32'hFFFF_CCCD, 1'b0);

    req_start("sat", 32'h7FFF_0000, 32'h8000_0000, 32'h0001_0000, 32'h0000_0001);
    check_result("sat", 37, 32'h7FFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);

    // Busy protocol: strobes at T0+5 and in the DONE cycle must be dropped.
    req_start("bp", 32'h0001_0000, 32'hFFFE_0000, 32'h0000_8000, 32'h0002_0000);
    repeat (4) @(posedge clk);
    #1;
    drive(32'h0007_0000, 32'h0, 32'h0, 32'h0001_0000);
    @(posedge clk);
    #1;
    strobe = 1'b0;
    chk("bp_busy_t5", {31'd0, busy}, 32'd1);
    repeat (31) @(posedge clk);
    #1;
    chk("bp_done_valid", {31'd0, valid}, 32'd0);
    chk("bp_done_busy", {31'd0, busy}, 32'd1);
    drive(32'h0007_0000, 32'h0, 32'h0, 32'h0001_0000);
    @(posedge clk);
    #1;
    strobe = 1'b0;
    chk("bp_valid", {31'd0, valid}, 32'd1);
    chk("bp_nx", norm_x, 32'h0000_8000);
    chk("bp_ny", norm_y, 32'hFFFF_0000);
    chk("bp_nz", norm_z, 32'h0000_4000);
    chk("bp_busy_v", {31'd0, busy}, 32'd0);
    req_start("b2b", 32'h0, 32'h0005_0000, 32'hFFFE_0000, 32'h000A_0000);
    check_result("b2b", 37, 32'h0, 32'h0000_8000, 32'hFFFF_CCCD, 1'b0);

    // Asynchronous reset in the middle of the second component.
    req_start("abort", 32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0005_0000);
    repeat (19) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_dz", {31'd0, div_zero}, 32'd0);
    chk("arst_nx", norm_x, 32'd0);
    chk("arst_ny", norm_y, 32'd0);
    chk("arst_nz", norm_z, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    nv = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk);
      #1;
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_idle_busy", {31'd0, busy}, 32'd0);

    req_start("fresh", 32'hFFFD_0000, 32'h0004_0000, 32'hFFFF_0000, 32'h0005_0000);
    check_result("fresh", 37, 32'hFFFF_6667, 32'h0000_CCCC, 32'hFFFF_CCCD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
